// File: rtl/lsu_wb_master.sv
// ============================================================================
// Module   : lsu_wb_master
// Purpose  : Load/store unit bus master. Takes one CPU load/store request at
//            a time, screens it for misalignment/illegal funct3, runs a
//            Wishbone-style stb/ack cycle bounded by a timeout and returns
//            exactly one response per request.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_wb_master #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TIMEOUT_W      = 5
) (
  input  logic        i_clk,
  input  logic        i_reset,
  // CPU request side
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [2:0]  i_req_funct3,
  // CPU response side
  output logic        o_resp_valid,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_err,
  // Bus master port
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [31:0] o_wb_addr,
  output logic [31:0] o_wb_data,
  output logic [2:0]  o_wb_sel,
  input  logic [31:0] i_wb_data,
  input  logic        i_wb_ack,
  input  logic        i_wb_stall
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] REQ      = 2'd1;
  localparam logic [1:0] WAIT_ACK = 2'd2;
  localparam logic [1:0] RESP     = 2'd3;

  // Last counter value of a bus cycle; reaching it without an ack aborts.
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]           state;
  logic [1:0]           next_state;
  logic [TIMEOUT_W-1:0] count;

  logic                 illegal;
  logic                 misaligned;
  logic                 reject;
  logic                 ack_taken;
  logic                 timed_out;

  logic                 bus_we;
  logic [31:0]          bus_addr;
  logic [31:0]          bus_data;
  logic [2:0]           bus_sel;
  logic [31:0]          resp_rdata;
  logic                 resp_err;

  // Screen the incoming request before any bus cycle is started.
  always_comb begin
    illegal    = (i_req_funct3 == 3'b011) || (i_req_funct3 == 3'b110) ||
                 (i_req_funct3 == 3'b111) || (i_req_we && i_req_funct3[2]);
    // funct3[1:0] == 01 covers both H and HU.
    misaligned = ((i_req_funct3[1:0] == 2'b01) && i_req_addr[0]) ||
                 ((i_req_funct3 == 3'b010) && (i_req_addr[1:0] != 2'b00));
    reject     = illegal || misaligned;
  end

  // An ack only counts once the strobe has been accepted (or in the same
  // cycle it is accepted); acks seen while stalled, idle or responding are
  // ignored.
  assign ack_taken = ((state == REQ) && !i_wb_stall && i_wb_ack) ||
                     ((state == WAIT_ACK) && i_wb_ack);
  assign timed_out = (count == TIMEOUT_LAST);

  // State register; reset drops the strobe and any pending response at once.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode; an ack beats a timeout in the same cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (i_req_valid) begin
          next_state = reject ? RESP : REQ;
        end
      end
      REQ: begin
        if (ack_taken || timed_out) begin
          next_state = RESP;
        end else if (!i_wb_stall) begin
          next_state = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ack_taken || timed_out) begin
          next_state = RESP;
        end
      end
      RESP: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State-decoded handshake outputs.
  always_comb begin
    o_req_ready  = (state == IDLE);
    o_wb_stb     = (state == REQ);
    o_resp_valid = (state == RESP);
  end

  // Request latch, timeout counter and response payload.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      bus_we     <= 1'b0;
      bus_addr   <= 32'd0;
      bus_data   <= 32'd0;
      bus_sel    <= 3'd0;
      count      <= '0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req_valid) begin
            bus_we     <= i_req_we;
            bus_addr   <= i_req_addr;
            bus_data   <= i_req_wdata;
            bus_sel    <= i_req_funct3;
            count      <= '0;
            resp_rdata <= 32'd0;
            resp_err   <= reject;
          end
        end
        REQ, WAIT_ACK: begin
          count <= count + 1'b1;
          if (ack_taken) begin
            resp_rdata <= bus_we ? 32'd0 : i_wb_data;
            resp_err   <= 1'b0;
          end else if (timed_out) begin
            resp_rdata <= 32'd0;
            resp_err   <= 1'b1;
          end
        end
        default: begin
          // Payload is only visible during RESP; clear it on the way out.
          resp_rdata <= 32'd0;
          resp_err   <= 1'b0;
        end
      endcase
    end
  end

  assign o_wb_we      = bus_we;
  assign o_wb_addr    = bus_addr;
  assign o_wb_data    = bus_data;
  assign o_wb_sel     = bus_sel;
  assign o_resp_rdata = resp_rdata;
  assign o_resp_err   = resp_err;

endmodule

`default_nettype wire

// File: tb/tb_lsu_wb_master.sv
// ============================================================================
// Module   : tb_lsu_wb_master
// Purpose  : Directed self-checking bench for lsu_wb_master.
// Revision : 1.1 - inline comparisons
// ============================================================================
`default_nettype none

module tb_lsu_wb_master;

    logic        r_clk = 1'b0;
    logic        r_rst;
    logic        r_req_valid;
    logic        w_req_ready;
    logic        r_req_we;
    logic [31:0] r_req_addr;
    logic [31:0] r_req_wdata;
    logic [2:0]  r_req_funct3;
    logic        w_resp_valid;
    logic [31:0] w_resp_rdata;
    logic        w_resp_err;
    logic        w_wb_stb;
    logic        w_wb_we;
    logic [31:0] w_wb_addr;
    logic [31:0] w_wb_data_o;
    logic [2:0]  w_wb_sel;
    logic [31:0] r_wb_data_i;
    logic        r_wb_ack;
    logic        r_wb_stall;

    int r_vectors     = 0;
    int r_miscompares = 0;
    int r_cycles;

    lsu_wb_master #(
        .TIMEOUT_CYCLES(16),
        .TIMEOUT_W     (5)
    ) dut (
        .i_clk        (r_clk),
        .i_reset      (r_rst),
        .i_req_valid  (r_req_valid),
        .o_req_ready  (w_req_ready),
        .i_req_we     (r_req_we),
        .i_req_addr   (r_req_addr),
        .i_req_wdata  (r_req_wdata),
        .i_req_funct3 (r_req_funct3),
        .o_resp_valid (w_resp_valid),
        .o_resp_rdata (w_resp_rdata),
        .o_resp_err   (w_resp_err),
        .o_wb_stb     (w_wb_stb),
        .o_wb_we      (w_wb_we),
        .o_wb_addr    (w_wb_addr),
        .o_wb_data    (w_wb_data_o),
        .o_wb_sel     (w_wb_sel),
        .i_wb_data    (r_wb_data_i),
        .i_wb_ack     (r_wb_ack),
        .i_wb_stall   (r_wb_stall)
    );

    always #5 r_clk = ~r_clk;

    task automatic fail(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        r_miscompares++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge r_clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] f3);
        r_req_valid  = 1'b1;
        r_req_we     = we;
        r_req_addr   = addr;
        r_req_wdata  = wdata;
        r_req_funct3 = f3;
        step();
        r_req_valid  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        r_rst        = 1'b1;
        r_req_valid  = 1'b0;
        r_req_we     = 1'b0;
        r_req_addr   = 32'd0;
        r_req_wdata  = 32'd0;
        r_req_funct3 = 3'd0;
        r_wb_data_i  = 32'd0;
        r_wb_ack     = 1'b0;
        r_wb_stall   = 1'b0;

        step();
        r_vectors++; if (w_req_ready !== 1'b1) fail("rst_ready", w_req_ready, 1'b1);
        r_vectors++; if (w_wb_stb !== 1'b0) fail("rst_stb", w_wb_stb, 1'b0);
        r_vectors++; if (w_resp_valid !== 1'b0) fail("rst_resp_valid", w_resp_valid, 1'b0);
        r_vectors++; if (w_wb_addr !== 32'd0) fail("rst_addr", w_wb_addr, 32'd0);
        r_vectors++; if (w_wb_sel !== 3'd0) fail("rst_sel", w_wb_sel, 3'd0);
        r_vectors++; if (w_resp_rdata !== 32'd0) fail("rst_rdata", w_resp_rdata, 32'd0);
        r_rst = 1'b0;
        step();

        issue(1'b0, 32'h0000_0100, 32'd0, 3'b010);
        r_vectors++; if (w_wb_stb !== 1'b1) fail("lw_stb", w_wb_stb, 1'b1);
        r_vectors++; if (w_wb_sel !== 3'b010) fail("lw_sel", w_wb_sel, 3'b010);
        r_vectors++; if (w_wb_addr !== 32'h0000_0100) fail("lw_addr", w_wb_addr, 32'h0000_0100);
        r_vectors++; if (w_wb_we !== 1'b0) fail("lw_we", w_wb_we, 1'b0);
        r_vectors++; if (w_req_ready !== 1'b0) fail("lw_ready_busy", w_req_ready, 1'b0);
        step();
        r_vectors++; if (w_wb_stb !== 1'b0) fail("lw_stb_single", w_wb_stb, 1'b0);
        r_vectors++; if (w_resp_valid !== 1'b0) fail("lw_no_early_resp", w_resp_valid, 1'b0);
        r_wb_ack    = 1'b1;
        r_wb_data_i = 32'hDEAD_BEEF;
        step();
        r_wb_ack = 1'b0;
        r_vectors++; if (w_resp_valid !== 1'b1) fail("lw_resp_valid", w_resp_valid, 1'b1);
        r_vectors++; if (w_resp_rdata !== 32'hDEAD_BEEF) fail("lw_rdata", w_resp_rdata, 32'hDEAD_BEEF);
        r_vectors++; if (w_resp_err !== 1'b0) fail("lw_err", w_resp_err, 1'b0);
        step();
        r_vectors++; if (w_resp_valid !== 1'b0) fail("lw_resp_one_cycle", w_resp_valid, 1'b0);
        r_vectors++; if (w_req_ready !== 1'b1) fail("lw_ready_again", w_req_ready, 1'b1);

        r_wb_data_i = 32'h1234_5678;
        issue(1'b1, 32'h0000_0103, 32'h0000_00A5, 3'b000);
        r_wb_stall = 1'b1;
        r_wb_ack   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            r_wb_ack = 1'b0;
            r_vectors++; if (w_wb_stb !== 1'b1) fail("sb_stall_stb", w_wb_stb, 1'b1);
            r_vectors++; if (w_wb_addr !== 32'h0000_0103) fail("sb_stall_addr", w_wb_addr, 32'h0000_0103);
            r_vectors++; if (w_wb_data_o !== 32'h0000_00A5) fail("sb_stall_data", w_wb_data_o, 32'h0000_00A5);
            r_vectors++; if (w_wb_sel !== 3'b000) fail("sb_stall_sel", w_wb_sel, 3'b000);
            r_vectors++; if (w_wb_we !== 1'b1) fail("sb_stall_we", w_wb_we, 1'b1);
            r_vectors++; if (w_resp_valid !== 1'b0) fail("sb_stall_no_resp", w_resp_valid, 1'b0);
        end
        r_wb_stall = 1'b0;
        step();
        r_vectors++; if (w_wb_stb !== 1'b0) fail("sb_stb_dropped", w_wb_stb, 1'b0);
        r_wb_ack = 1'b1;
        step();
        r_wb_ack = 1'b0;
        r_vectors++; if (w_resp_valid !== 1'b1) fail("sb_resp_valid", w_resp_valid, 1'b1);
        r_vectors++; if (w_resp_err !== 1'b0) fail("sb_err", w_resp_err, 1'b0);
        r_vectors++; if (w_resp_rdata !== 32'd0) fail("sb_rdata_zero", w_resp_rdata, 32'd0);
        step();

        issue(1'b0, 32'h0000_0101, 32'd0, 3'b001);
        r_vectors++; if (w_resp_valid !== 1'b1) fail("lh_mis_resp", w_resp_valid, 1'b1);
        r_vectors++; if (w_resp_err !== 1'b1) fail("lh_mis_err", w_resp_err, 1'b1);
        r_vectors++; if (w_wb_stb !== 1'b0) fail("lh_mis_stb", w_wb_stb, 1'b0);
        step();
        r_vectors++; if (w_wb_stb !== 1'b0) fail("lh_mis_stb_after", w_wb_stb, 1'b0);
        issue(1'b1, 32'h0000_0102, 32'h5555_5555, 3'b010);
        r_vectors++; if (w_resp_valid !== 1'b1) fail("sw_mis_resp", w_resp_valid, 1'b1);
        r_vectors++; if (w_resp_err !== 1'b1) fail("sw_mis_err", w_resp_err, 1'b1);
        r_vectors++; if (w_wb_stb !== 1'b0) fail("sw_mis_stb", w_wb_stb, 1'b0);
        step();
        issue(1'b0, 32'h0000_0000, 32'd0, 3'b011);
        r_vectors++; if (w_resp_valid !== 1'b1) fail("f3_011_resp", w_resp_valid, 1'b1);
        r_vectors++; if (w_resp_err !== 1'b1) fail("f3_011_err", w_resp_err, 1'b1);
        step();
        issue(1'b1, 32'h0000_0000, 32'd0, 3'b100);
        r_vectors++; if (w_resp_err !== 1'b1) fail("sbu_err", w_resp_err, 1'b1);
        r_vectors++; if (w_wb_stb !== 1'b0) fail("sbu_stb", w_wb_stb, 1'b0);
        step();
        issue(1'b0, 32'h0000_0102, 32'd0, 3'b101);
        r_vectors++; if (w_wb_stb !== 1'b1) fail("lhu_ok_stb", w_wb_stb, 1'b1);
        r_vectors++; if (w_resp_valid !== 1'b0) fail("lhu_ok_no_resp", w_resp_valid, 1'b0);
        r_wb_ack    = 1'b1;
        r_wb_data_i = 32'h0000_BEEF;
        step();
        r_wb_ack = 1'b0;
        r_vectors++; if (w_resp_rdata !== 32'h0000_BEEF) fail("lhu_ok_rdata", w_resp_rdata, 32'h0000_BEEF);
        r_vectors++; if (w_resp_err !== 1'b0) fail("lhu_ok_err", w_resp_err, 1'b0);
        step();

        issue(1'b0, 32'h2000_0000, 32'd0, 3'b010);
        r_vectors++; if (w_wb_stb !== 1'b1) fail("to_stb_rose", w_wb_stb, 1'b1);
        r_cycles = 0;
        while (!w_resp_valid && r_cycles < 40) begin
            step();
            r_cycles++;
        end
        r_vectors++; if (r_cycles != 16) fail("to_latency", r_cycles, 16);
        r_vectors++; if (w_resp_valid !== 1'b1) fail("to_resp", w_resp_valid, 1'b1);
        r_vectors++; if (w_resp_err !== 1'b1) fail("to_err", w_resp_err, 1'b1);
        r_vectors++; if (w_resp_rdata !== 32'd0) fail("to_rdata", w_resp_rdata, 32'd0);
        r_vectors++; if (w_wb_stb !== 1'b0) fail("to_stb_low", w_wb_stb, 1'b0);
        step();

        r_wb_ack = 1'b1;
        step();
        r_vectors++; if (w_resp_valid !== 1'b0) fail("idle_ack_no_resp0", w_resp_valid, 1'b0);
        step();
        r_vectors++; if (w_resp_valid !== 1'b0) fail("idle_ack_no_resp1", w_resp_valid, 1'b0);
        r_wb_ack = 1'b0;
        issue(1'b1, 32'hFFFF_FFF2, 32'h0000_0001, 3'b001);
        r_vectors++; if (w_wb_stb !== 1'b1) fail("sd_stb", w_wb_stb, 1'b1);
        r_vectors++; if (w_wb_addr !== 32'hFFFF_FFF2) fail("sd_addr", w_wb_addr, 32'hFFFF_FFF2);
        r_vectors++; if (w_wb_data_o !== 32'h0000_0001) fail("sd_data", w_wb_data_o, 32'h0000_0001);
        r_wb_ack = 1'b1;
        step();
        r_vectors++; if (w_resp_valid !== 1'b1) fail("sd_resp_n2", w_resp_valid, 1'b1);
        r_vectors++; if (w_resp_err !== 1'b0) fail("sd_err", w_resp_err, 1'b0);
        r_vectors++; if (w_resp_rdata !== 32'd0) fail("sd_rdata", w_resp_rdata, 32'd0);
        step();
        r_vectors++; if (w_resp_valid !== 1'b0) fail("sd_no_second_resp0", w_resp_valid, 1'b0);
        step();
        r_vectors++; if (w_resp_valid !== 1'b0) fail("sd_no_second_resp1", w_resp_valid, 1'b0);
        r_wb_ack = 1'b0;

        issue(1'b0, 32'h0000_0300, 32'd0, 3'b010);
        step();
        r_vectors++; if (w_wb_stb !== 1'b0) fail("rw_in_wait", w_wb_stb, 1'b0);
        r_rst = 1'b1;
        #1;
        r_vectors++; if (w_req_ready !== 1'b1) fail("rw_async_ready", w_req_ready, 1'b1);
        r_vectors++; if (w_wb_stb !== 1'b0) fail("rw_async_stb", w_wb_stb, 1'b0);
        r_vectors++; if (w_resp_valid !== 1'b0) fail("rw_async_resp", w_resp_valid, 1'b0);
        step();
        r_rst    = 1'b0;
        r_wb_ack = 1'b1;
        step();
        r_vectors++; if (w_resp_valid !== 1'b0) fail("rw_no_resp0", w_resp_valid, 1'b0);
        step();
        r_vectors++; if (w_resp_valid !== 1'b0) fail("rw_no_resp1", w_resp_valid, 1'b0);
        r_wb_ack = 1'b0;
        issue(1'b0, 32'h0000_0400, 32'd0, 3'b010);
        r_wb_stall = 1'b1;
        r_vectors++; if (w_wb_stb !== 1'b1) fail("rs_stb_before", w_wb_stb, 1'b1);
        r_rst = 1'b1;
        #1;
        r_vectors++; if (w_wb_stb !== 1'b0) fail("rs_async_stb", w_wb_stb, 1'b0);
        step();
        r_rst      = 1'b0;
        r_wb_stall = 1'b0;
        step();

        issue(1'b0, 32'h0000_0010, 32'd0, 3'b100);
        r_vectors++; if (w_wb_stb !== 1'b1) fail("lbu_stb", w_wb_stb, 1'b1);
        r_vectors++; if (w_wb_sel !== 3'b100) fail("lbu_sel", w_wb_sel, 3'b100);
        r_vectors++; if (w_wb_addr !== 32'h0000_0010) fail("lbu_addr", w_wb_addr, 32'h0000_0010);
        step();
        r_wb_ack    = 1'b1;
        r_wb_data_i = 32'h0000_00C3;
        step();
        r_wb_ack = 1'b0;
        r_vectors++; if (w_resp_valid !== 1'b1) fail("lbu_resp", w_resp_valid, 1'b1);
        r_vectors++; if (w_resp_rdata !== 32'h0000_00C3) fail("lbu_rdata", w_resp_rdata, 32'h0000_00C3);
        r_vectors++; if (w_resp_err !== 1'b0) fail("lbu_err", w_resp_err, 1'b0);
        step();
        r_vectors++; if (w_req_ready !== 1'b1) fail("lbu_idle", w_req_ready, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", r_vectors, r_miscompares);
        $finish;
    end

endmodule

`default_nettype wire
